// File: rtl/wb_retire_queue.sv
// Writeback stage register with per-lane RF/HI/LO writes and serialized trace FIFO.
// Optional retire counter built only when WB_RETIRE_CNT_EN is defined.
module wb_retire_queue #(
  parameter int LANES       = 2,
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES*XLEN-1:0] in_pc,
  input  logic [LANES-1:0]      in_rf_we,
  input  logic [LANES*5-1:0]    in_rf_waddr,
  input  logic [LANES*XLEN-1:0] in_rf_wdata,
  input  logic [LANES-1:0]      in_hi_we,
  input  logic [LANES-1:0]      in_lo_we,
  input  logic [LANES*XLEN-1:0] in_hi,
  input  logic [LANES*XLEN-1:0] in_lo,
  output logic [LANES-1:0]      rf_we,
  output logic [LANES*5-1:0]    rf_waddr,
  output logic [LANES*XLEN-1:0] rf_wdata,
  output logic                  hi_we,
  output logic                  lo_we,
  output logic [XLEN-1:0]       hi_o,
  output logic [XLEN-1:0]       lo_o,
  output logic [XLEN-1:0]       debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [XLEN-1:0]       debug_wb_rf_wdata,
  output logic                  stallreq_wb,
  output logic [31:0]           retire_cnt
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;

  logic [LANES-1:0]      r_valid, r_we, r_hi_we, r_lo_we;
  logic [LANES*XLEN-1:0] r_pc, r_wdata, r_hi, r_lo;
  logic [LANES*5-1:0]    r_waddr;

  logic [LANES-1:0]      w_valid, w_we, w_hi_we, w_lo_we;
  logic [LANES*XLEN-1:0] w_pc, w_wdata, w_hi, w_lo;
  logic [LANES*5-1:0]    w_waddr;

  logic w_bubble, w_load, w_adv;
  logic w_unused;

  assign w_bubble = (stall[4] & ~stall[5]) | flush;
  assign w_load   = ~stall[4] & ~flush;
  assign w_adv    = w_bubble | w_load;
  assign w_unused = ^stall[3:0];

  always_comb begin
    w_valid = '0;
    w_we    = '0;
    w_hi_we = '0;
    w_lo_we = '0;
    w_pc    = '0;
    w_wdata = '0;
    w_hi    = '0;
    w_lo    = '0;
    w_waddr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        w_valid[i] = 1'b1;
        w_we[i]    = in_rf_we[i];
        w_hi_we[i] = in_hi_we[i];
        w_lo_we[i] = in_lo_we[i];
        w_pc[i*XLEN +: XLEN]    = in_pc[i*XLEN +: XLEN];
        w_wdata[i*XLEN +: XLEN] = in_rf_wdata[i*XLEN +: XLEN];
        w_hi[i*XLEN +: XLEN]    = in_hi[i*XLEN +: XLEN];
        w_lo[i*XLEN +: XLEN]    = in_lo[i*XLEN +: XLEN];
        w_waddr[i*5 +: 5]       = in_rf_waddr[i*5 +: 5];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_we    <= '0;
      r_hi_we <= '0;
      r_lo_we <= '0;
      r_pc    <= '0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_waddr <= '0;
    end else begin
      unique case (1'b1)
        w_bubble: begin
          r_valid <= '0;
          r_we    <= '0;
          r_hi_we <= '0;
          r_lo_we <= '0;
          r_pc    <= '0;
          r_wdata <= '0;
          r_hi    <= '0;
          r_lo    <= '0;
          r_waddr <= '0;
        end
        w_load: begin
          r_valid <= w_valid;
          r_we    <= w_we;
          r_hi_we <= w_hi_we;
          r_lo_we <= w_lo_we;
          r_pc    <= w_pc;
          r_wdata <= w_wdata;
          r_hi    <= w_hi;
          r_lo    <= w_lo;
          r_waddr <= w_waddr;
        end
        default: ;
      endcase
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign hi_we    = |r_hi_we;
  assign lo_we    = |r_lo_we;

  // Highest lane wins when several lanes write HI/LO together.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_hi_we[i]) hi_o = r_hi[i*XLEN +: XLEN];
      if (r_lo_we[i]) lo_o = r_lo[i*XLEN +: XLEN];
    end
  end

  logic [XLEN-1:0] r_mpc [TRACE_DEPTH];
  logic [XLEN-1:0] r_mwd [TRACE_DEPTH];
  logic [4:0]      r_mwa [TRACE_DEPTH];
  logic            r_mwe [TRACE_DEPTH];

  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic [CW-1:0] w_space, w_npush;
  logic [LANES-1:0] w_push;
  logic [PW-1:0] w_widx [LANES];

  assign w_pop   = (r_cnt != '0);
  assign w_space = CW'(TRACE_DEPTH) - r_cnt + CW'(w_pop);

  // Lanes claim consecutive slots; later lanes drop once space runs out.
  always_comb begin
    w_npush = '0;
    w_push  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_widx[i] = r_wr + w_npush[PW-1:0];
      if (w_adv && r_valid[i] && (w_npush < w_space)) begin
        w_push[i] = 1'b1;
        w_npush   = w_npush + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_push[i]) begin
        r_mpc[w_widx[i]] <= r_pc[i*XLEN +: XLEN];
        r_mwd[w_widx[i]] <= r_wdata[i*XLEN +: XLEN];
        r_mwa[w_widx[i]] <= r_waddr[i*5 +: 5];
        r_mwe[w_widx[i]] <= r_we[i];
      end
    end
  end

  logic [XLEN-1:0] r_dpc, r_dwd;
  logic [4:0]      r_dwa;
  logic            r_dwe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_dpc <= '0;
      r_dwd <= '0;
      r_dwa <= '0;
      r_dwe <= 1'b0;
    end else begin
      r_wr  <= r_wr + w_npush[PW-1:0];
      r_rd  <= r_rd + PW'(w_pop);
      r_cnt <= r_cnt + w_npush - CW'(w_pop);
      if (w_pop) begin
        r_dpc <= r_mpc[r_rd];
        r_dwd <= r_mwd[r_rd];
        r_dwa <= r_mwa[r_rd];
        r_dwe <= r_mwe[r_rd];
      end else begin
        r_dpc <= '0;
        r_dwd <= '0;
        r_dwa <= '0;
        r_dwe <= 1'b0;
      end
    end
  end

  assign debug_wb_pc       = r_dpc;
  assign debug_wb_rf_wen   = {4{r_dwe}};
  assign debug_wb_rf_wnum  = r_dwa;
  assign debug_wb_rf_wdata = r_dwd;
  assign stallreq_wb       = (r_cnt > CW'(TRACE_DEPTH - LANES));

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_retire <= '0;
    else      r_retire <= r_retire + 32'(w_npush);
  end
  assign retire_cnt = r_retire;
`else
  assign retire_cnt = '0;
`endif

endmodule
